// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an icache and a dcache.
// Fixed dcache priority with an icache anti-starvation override, plus a
// 16-entry owner table that routes tagged load data back to its requester.
module mem_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      icache2arb_command,
  input  logic [XLEN-1:0] icache2arb_addr,
  input  logic [1:0]      dcache2arb_command,
  input  logic [XLEN-1:0] dcache2arb_addr,
  input  logic [63:0]     dcache2arb_data,
  output logic [3:0]      arb2icache_response,
  output logic [63:0]     arb2icache_data,
  output logic [3:0]      arb2icache_tag,
  output logic [3:0]      arb2dcache_response,
  output logic [63:0]     arb2dcache_data,
  output logic [3:0]      arb2dcache_tag,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic            grant_dcache,
  output logic [4:0]      outstanding_count,
  output logic            stray_tag
);

  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  logic [SW-1:0] starve_q, starve_d;
  logic [15:0]   valid_q, valid_d;
  logic [15:0]   owner_q, owner_d;   // 1 = dcache owns the tag
  logic [4:0]    count_q, count_d;
  logic          stray_q, stray_d;

  logic ic_req, dc_req, starve_max;
  logic gnt_ic, gnt_dc;
  logic retire_hit, retire_miss, alloc, realloc;

  // Arbitration: dcache wins ties unless the icache has been starved to the limit
  always_comb begin
    ic_req     = !reset && (icache2arb_command == CMD_LOAD);
    dc_req     = !reset && ((dcache2arb_command == CMD_LOAD) ||
                            (dcache2arb_command == CMD_STORE));
    starve_max = (starve_q == SW'(STARVE_LIMIT));
    gnt_ic     = ic_req && (!dc_req || starve_max);
    gnt_dc     = dc_req && !gnt_ic;
    if (ic_req && !gnt_ic) begin
      starve_d = starve_max ? starve_q : starve_q + SW'(1);
    end else begin
      starve_d = '0;
    end
  end

  // Owner table update: retire first, then allocate, so a same-tag
  // retire/allocate pair routes to the old owner and leaves the new one.
  always_comb begin
    retire_hit  = !reset && (mem2proc_tag != 4'd0) && valid_q[mem2proc_tag];
    retire_miss = !reset && (mem2proc_tag != 4'd0) && !valid_q[mem2proc_tag];
    alloc       = !reset && (mem2proc_response != 4'd0) &&
                  (gnt_ic || (gnt_dc && (dcache2arb_command == CMD_LOAD)));
    realloc     = alloc && valid_q[mem2proc_response] &&
                  !(retire_hit && (mem2proc_tag == mem2proc_response));
    stray_d     = retire_miss || realloc;

    valid_d = valid_q;
    owner_d = owner_q;
    if (retire_hit) begin
      valid_d[mem2proc_tag] = 1'b0;
    end
    if (alloc) begin
      valid_d[mem2proc_response] = 1'b1;
      owner_d[mem2proc_response] = gnt_dc;
    end

    count_d = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      count_d = count_d + 5'(valid_d[i]);
    end
  end

  // Memory port mux, response steering and returned-data routing
  always_comb begin
    proc2mem_command = CMD_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (gnt_ic) begin
      proc2mem_command = icache2arb_command;
      proc2mem_addr    = icache2arb_addr;
    end else if (gnt_dc) begin
      proc2mem_command = dcache2arb_command;
      proc2mem_addr    = dcache2arb_addr;
      if (dcache2arb_command == CMD_STORE) begin
        proc2mem_data = dcache2arb_data;
      end
    end

    grant_dcache        = gnt_dc;
    arb2icache_response = gnt_ic ? mem2proc_response : 4'd0;
    arb2dcache_response = gnt_dc ? mem2proc_response : 4'd0;

    arb2icache_tag  = '0;
    arb2icache_data = '0;
    arb2dcache_tag  = '0;
    arb2dcache_data = '0;
    if (retire_hit) begin
      if (owner_q[mem2proc_tag]) begin
        arb2dcache_tag  = mem2proc_tag;
        arb2dcache_data = mem2proc_data;
      end else begin
        arb2icache_tag  = mem2proc_tag;
        arb2icache_data = mem2proc_data;
      end
    end

    outstanding_count = count_q;
    stray_tag         = stray_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
      valid_q  <= '0;
      owner_q  <= '0;
      count_q  <= '0;
      stray_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      valid_q  <= valid_d;
      owner_q  <= owner_d;
      count_q  <= count_d;
      stray_q  <= stray_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive icache denials before the icache is forced priority.
REQ-002 clock  input  1  system clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 icache2arb_command  input  2  0 none, 1 load; value 2 treated as none.
REQ-005 icache2arb_addr  input  XLEN  icache request address.
REQ-006 dcache2arb_command  input  2  0 none, 1 load, 2 store.
REQ-007 dcache2arb_addr  input  XLEN  dcache request address.
REQ-008 dcache2arb_data  input  64  dcache store data.
REQ-009 arb2icache_response  output  4  nonzero = icache request accepted this cycle, value is the memory tag.
REQ-010 arb2icache_data  output  64  returned load data for icache.
REQ-011 arb2icache_tag  output  4  nonzero = arb2icache_data valid for this tag.
REQ-012 arb2dcache_response  output  4  as REQ-009, for dcache.
REQ-013 arb2dcache_data  output  64  returned load data for dcache.
REQ-014 arb2dcache_tag  output  4  as REQ-011, for dcache.
REQ-015 proc2mem_command  output  2  command to the single memory port.
REQ-016 proc2mem_addr  output  XLEN  address to memory.
REQ-017 proc2mem_data  output  64  store data to memory, 0 when the command is not a store.
REQ-018 mem2proc_response  input  4  nonzero = memory accepted the issued command, value is the tag.
REQ-019 mem2proc_data  input  64  load data returned by memory.
REQ-020 mem2proc_tag  input  4  nonzero = mem2proc_data belongs to this tag.
REQ-021 grant_dcache  output  1  1 = dcache owns the memory port this cycle.
REQ-022 outstanding_count  output  5  number of valid owner-table entries, 0..15.
REQ-023 stray_tag  output  1  one-cycle pulse flagging a protocol error (REQ-031, REQ-032).

Function
REQ-024 Grant is combinational: when only one requester has a nonzero command, that requester gets the port.
REQ-025 When both request, dcache wins, unless starve_cnt == STARVE_LIMIT, in which case icache wins.
REQ-026 starve_cnt (registered) increments when icache requests and is denied; it resets to 0 on any icache grant or any cycle without an icache request; it saturates at STARVE_LIMIT.
REQ-027 The granted requester's command, address and data drive proc2mem_* in the same cycle; with no grant, proc2mem_command is 0 and proc2mem_addr/data are 0.
REQ-028 mem2proc_response is copied only to the granted requester's arb2*_response; the other requester sees 0.
REQ-029 Owner table: 16 entries, each a valid bit plus an owner bit. An accepted load (nonzero response) sets entry[response] valid with the grantee as owner at the clock edge. Stores are never entered.
REQ-030 A nonzero mem2proc_tag with entry[tag] valid routes mem2proc_data and the tag to the owner's arb2*_data/tag in the same cycle; the other requester sees tag 0, data 0. The entry clears at the edge.
REQ-031 A nonzero mem2proc_tag with entry[tag] invalid is dropped (both requesters see tag 0) and pulses stray_tag.
REQ-032 An accepted load whose response tag is already valid overwrites the entry with the new owner and pulses stray_tag.
REQ-033 Same-cycle retire and allocate of one tag: the retire routes to the old owner first, and the entry ends valid with the new owner.
REQ-034 outstanding_count is registered and equals the popcount of valid entries after each edge.

Reset
REQ-035 On reset at a clock edge: all table entries invalid, starve_cnt = 0, outstanding_count = 0, stray_tag = 0; in-flight responses arriving after reset are dropped per REQ-031.
REQ-036 While reset is high, proc2mem_command = 0 and all arb2* response/tag outputs = 0.

Verification
REQ-037 Dcache load addr 0x100, mem response 3; two cycles later mem tag 3, data 88 -> arb2dcache_response = 3, then arb2dcache_tag = 3 with data 88; arb2icache_tag = 0; outstanding_count goes 1 then 0.
REQ-038 Both requesters issue loads for 6 cycles, memory always accepts -> dcache is granted 4 cycles, icache is granted the 5th, dcache the 6th; starve_cnt returns to 0.
REQ-039 Dcache store addr 0x8, data 4, response 5 -> proc2mem_command = 2, proc2mem_data = 4; outstanding_count stays 0.
REQ-040 mem2proc_tag = 7 with no outstanding entry -> stray_tag pulses one cycle; both arb2*_tag = 0.
REQ-041 Icache owns tag 2; in one cycle mem tag 2 retires while a dcache load is accepted with response 2 -> icache receives the data; entry 2 now owned by dcache; count unchanged.
REQ-042 Reset asserted with 3 tags outstanding -> outstanding_count = 0 next cycle; a later mem tag for any of those tags pulses stray_tag.
